// File: rtl/input_event_arbiter.sv
// Merges debounced button pulses and pitch-detector mic pulses into one command FIFO.
// Each source has a one-entry pending slot; a round-robin arbiter pushes at most one slot per cycle.
module input_event_arbiter #(
  parameter int COOLDOWN   = 10_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       mic_hi,
  input  logic       mic_lo,
  input  logic       mic_en,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic       cmd_src,
  output logic       fifo_full,
  output logic [7:0] drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic [1:0] CODE_UP   = 2'd0;
  localparam logic [1:0] CODE_DOWN = 2'd1;
  localparam logic [1:0] CODE_SEL  = 2'd2;
  localparam logic       SRC_BTN   = 1'b0;
  localparam logic       SRC_MIC   = 1'b1;

  logic          btn_pend_v, mic_pend_v;
  logic [1:0]    btn_pend_code, mic_pend_code;
  logic [CW-1:0] cooldown_cnt;
  logic          last_grant;

  logic [1:0]    fifo_code [FIFO_DEPTH];
  logic          fifo_src  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic          pop, push_ok, push, push_src;
  logic [1:0]    push_code;
  logic          grant_btn, grant_mic;

  logic          btn_any, btn_take, btn_block;
  logic [1:0]    btn_code, btn_hits, btn_losers;
  logic          mic_open, mic_both, mic_one, mic_take, mic_block;
  logic [1:0]    mic_code;
  logic [2:0]    drop_inc;
  logic [8:0]    drop_sum;

  assign cmd_valid = (count != '0);
  assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
  assign cmd_code  = cmd_valid ? fifo_code[rd_ptr] : 2'd0;
  assign cmd_src   = cmd_valid ? fifo_src[rd_ptr]  : 1'b0;

  assign pop     = cmd_valid && cmd_ready;
  assign push_ok = !fifo_full || pop;

  // last_grant only moves on contested cycles, so ties alternate regardless of solo grants in between
  always_comb begin
    grant_btn = 1'b0;
    grant_mic = 1'b0;
    if (push_ok) begin
      if (btn_pend_v && mic_pend_v) begin
        if (last_grant == SRC_MIC) grant_btn = 1'b1;
        else                       grant_mic = 1'b1;
      end else if (btn_pend_v) begin
        grant_btn = 1'b1;
      end else if (mic_pend_v) begin
        grant_mic = 1'b1;
      end
    end
  end

  assign push      = grant_btn || grant_mic;
  assign push_code = grant_btn ? btn_pend_code : mic_pend_code;
  assign push_src  = grant_mic ? SRC_MIC : SRC_BTN;

  assign btn_any    = btn_up || btn_down || btn_sel;
  assign btn_code   = btn_sel ? CODE_SEL : (btn_up ? CODE_UP : CODE_DOWN);
  assign btn_hits   = {1'b0, btn_up} + {1'b0, btn_down} + {1'b0, btn_sel};
  assign btn_losers = btn_any ? btn_hits - 2'd1 : 2'd0;
  assign btn_take   = btn_any && (!btn_pend_v || grant_btn);
  assign btn_block  = btn_any && !btn_take;

  // gated-off mic pulses are ignored outright and never count as drops
  assign mic_open  = mic_en && (cooldown_cnt == '0);
  assign mic_both  = mic_open && mic_hi && mic_lo;
  assign mic_one   = mic_open && (mic_hi ^ mic_lo);
  assign mic_code  = mic_hi ? CODE_UP : CODE_DOWN;
  assign mic_take  = mic_one && (!mic_pend_v || grant_mic);
  assign mic_block = mic_one && !mic_take;

  assign drop_inc = {1'b0, btn_losers} + {2'b00, btn_block} + {2'b00, mic_both} + {2'b00, mic_block};
  assign drop_sum = {1'b0, drop_count} + {6'd0, drop_inc};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      btn_pend_v    <= 1'b0;
      btn_pend_code <= 2'd0;
      mic_pend_v    <= 1'b0;
      mic_pend_code <= 2'd0;
      cooldown_cnt  <= '0;
      last_grant    <= SRC_MIC;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      drop_count    <= 8'd0;
    end else begin
      if (btn_take) begin
        btn_pend_v    <= 1'b1;
        btn_pend_code <= btn_code;
      end else if (grant_btn) begin
        btn_pend_v <= 1'b0;
      end

      if (mic_take) begin
        mic_pend_v    <= 1'b1;
        mic_pend_code <= mic_code;
      end else if (grant_mic) begin
        mic_pend_v <= 1'b0;
      end

      if (mic_take)                 cooldown_cnt <= CW'(COOLDOWN - 1);
      else if (cooldown_cnt != '0)  cooldown_cnt <= cooldown_cnt - CW'(1);

      if (btn_pend_v && mic_pend_v && push) last_grant <= push_src;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);

      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && push) begin
      fifo_code[wr_ptr] <= push_code;
      fifo_src[wr_ptr]  <= push_src;
    end
  end

endmodule
